// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_t : controller state encoding
//   REG_ZERO   : architectural zero register specifier (never a real hazard)
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        RUN   = 3'd1,
        LU    = 3'd2,
        MWAIT = 3'd3,
        FPEND = 3'd4
    } hz_state_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the optional performance counters.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low clear
//   inc    : increment enable for this cycle
//   count  : current count, sticks at all-ones
module sat_counter #(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    logic [PERF_W-1:0] cnt_q;
    logic [PERF_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / flush / bubble sequencing for the IF-ID-EX front end. Arbitrates
// post-reset hold, instruction-memory wait states, load-use hazards and
// taken-branch flushes. Outputs are decoded combinationally from state+inputs.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   imem_ready            : instruction memory data valid for current PC
//   branch_taken          : branch resolved taken this cycle
//   idex_mem_read, idex_rt: load in ID/EX and its destination
//   ifid_rs, ifid_rt      : sources of the IF/ID instruction
//   ifid_uses_rt          : IF/ID instruction reads rt
//   stall                 : hold PC and IF/ID
//   if_flush              : squash IF/ID, fetch redirects
//   idex_bubble           : zero ID/EX control fields
//   imem_req              : fetch request enable
//   stall_cycles          : saturating stall count (PIPE_HAZARD_PERF_EN only)
//   flush_count           : saturating flush count (PIPE_HAZARD_PERF_EN only)
// Build option: define PIPE_HAZARD_PERF_EN to add the performance counters.
//
// state | meaning
// HOLD  | post-reset hold, stall until hold counter reaches 0
// RUN   | normal fetch, branch > load-use > memory wait
// LU    | single load-use stall cycle already taken, re-check ignored
// MWAIT | waiting on instruction memory
// FPEND | taken branch seen during a wait, flush when memory returns
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int RESET_HOLD = 2,
    parameter int PERF_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  imem_ready,
    input  logic                  branch_taken,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rt,
    input  logic [REG_ADDR_W-1:0] ifid_rs,
    input  logic [REG_ADDR_W-1:0] ifid_rt,
    input  logic                  ifid_uses_rt,
    output logic                  stall,
    output logic                  if_flush,
    output logic                  idex_bubble,
    output logic                  imem_req
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]     stall_cycles,
    output logic [PERF_W-1:0]     flush_count
`endif
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);

    if (RESET_HOLD < 1 || PERF_W < 1) begin : g_bad_cfg
        $error("pipeline_hazard_ctrl: RESET_HOLD and PERF_W must be >= 1");
    end

    hz_state_t         state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              lu_hit;

    assign lu_hit = idex_mem_read
                  && (idex_rt != REG_ADDR_W'(REG_ZERO))
                  && ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        stall       = 1'b0;
        if_flush    = 1'b0;
        idex_bubble = 1'b0;
        imem_req    = 1'b1;
        case (state_q)
            HOLD: begin
                stall       = 1'b1;
                idex_bubble = 1'b1;
                imem_req    = 1'b0;
                if (hold_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            RUN: begin
                // Branch wins over load-use: the dependent instruction is squashed.
                if (branch_taken) begin
                    if_flush    = 1'b1;
                    idex_bubble = 1'b1;
                end else if (lu_hit) begin
                    stall       = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = LU;
                end else if (!imem_ready) begin
                    stall   = 1'b1;
                    state_d = MWAIT;
                end
            end
            LU: begin
                if (branch_taken) begin
                    if_flush    = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = RUN;
                end else if (!imem_ready) begin
                    state_d = MWAIT;
                end else begin
                    state_d = RUN;
                end
            end
            MWAIT: begin
                // Stall only while memory is still not ready, so a wait of
                // n not-ready cycles costs exactly n stall cycles.
                if (!imem_ready) begin
                    stall = 1'b1;
                    if (branch_taken) begin
                        state_d = FPEND;
                    end
                end else if (branch_taken) begin
                    // Memory returns in the same cycle: nothing left to defer.
                    if_flush    = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = RUN;
                end else begin
                    state_d = RUN;
                end
            end
            FPEND: begin
                // Further branches here are absorbed into the single pending flush.
                if (!imem_ready) begin
                    stall = 1'b1;
                end else begin
                    if_flush    = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = RUN;
                end
            end
            default: begin
                stall       = 1'b1;
                idex_bubble = 1'b1;
                imem_req    = 1'b0;
                state_d     = HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HOLD;
            hold_cnt_q <= HOLD_INIT;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    sat_counter #(.PERF_W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall && (state_q != HOLD)),
        .count (stall_cycles)
    );

    sat_counter #(.PERF_W(PERF_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_flush),
        .count (flush_count)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Expected output vectors
// {stall, if_flush, idex_bubble, imem_req} are queued when a cycle is driven
// and popped for comparison mid-cycle.
module tb_pipeline_hazard_ctrl;

    localparam int RA_W  = 5;
    localparam int RHOLD = 2;
    localparam int PW    = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            imem_ready = 1'b1;
    logic            branch_taken = 1'b0;
    logic            idex_mem_read = 1'b0;
    logic [RA_W-1:0] idex_rt = '0;
    logic [RA_W-1:0] ifid_rs = '0;
    logic [RA_W-1:0] ifid_rt = '0;
    logic            ifid_uses_rt = 1'b0;
    logic            stall, if_flush, idex_bubble, imem_req;
`ifdef PIPE_HAZARD_PERF_EN
    logic [PW-1:0]   stall_cycles, flush_count;
    int              exp_stall_cnt = 0;
    int              exp_flush_cnt = 0;
`endif

    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (RA_W),
        .RESET_HOLD (RHOLD),
        .PERF_W     (PW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_ready    (imem_ready),
        .branch_taken  (branch_taken),
        .idex_mem_read (idex_mem_read),
        .idex_rt       (idex_rt),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .ifid_uses_rt  (ifid_uses_rt),
        .stall         (stall),
        .if_flush      (if_flush),
        .idex_bubble   (idex_bubble),
        .imem_req      (imem_req)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // One cycle: called at posedge+1, returns at the next posedge+1.
    task automatic cyc(input string tag, input logic rdy, input logic br, input logic mr,
                       input logic [RA_W-1:0] irt, input logic [RA_W-1:0] rs,
                       input logic [RA_W-1:0] rt, input logic urt, input logic [3:0] want);
        logic [3:0] e_out;
        imem_ready    = rdy;
        branch_taken  = br;
        idex_mem_read = mr;
        idex_rt       = irt;
        ifid_rs       = rs;
        ifid_rt       = rt;
        ifid_uses_rt  = urt;
        exp_q.push_back(want);
`ifdef PIPE_HAZARD_PERF_EN
        // imem_req is low only in HOLD, whose stall is not counted.
        if (want[3] && want[0] && exp_stall_cnt < (2**PW - 1)) exp_stall_cnt++;
        if (want[2] && exp_flush_cnt < (2**PW - 1)) exp_flush_cnt++;
`endif
        @(negedge clk);
        e_out = exp_q.pop_front();
        chk(tag, {28'd0, stall, if_flush, idex_bubble, imem_req}, {28'd0, e_out});
        chk({tag, "_excl"}, {31'd0, stall & if_flush}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [3:0] want);
        cyc(tag, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, want);
    endtask

    task automatic mem_wait(input string tag, input logic br, input logic [3:0] want);
        cyc(tag, 1'b0, br, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, want);
    endtask

    task automatic lu_cyc(input string tag, input logic br, input logic [3:0] want);
        cyc(tag, 1'b1, br, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, want);
    endtask

    // {stall, if_flush, idex_bubble, imem_req}
    localparam logic [3:0] O_HOLD  = 4'b1010;
    localparam logic [3:0] O_IDLE  = 4'b0001;
    localparam logic [3:0] O_LU    = 4'b1011;
    localparam logic [3:0] O_FLUSH = 4'b0111;
    localparam logic [3:0] O_MSTL  = 4'b1001;

    initial begin
        #3;
        chk("rst_out", {28'd0, stall, if_flush, idex_bubble, imem_req}, {28'd0, O_HOLD});
`ifdef PIPE_HAZARD_PERF_EN
        chk("rst_stall_cnt", 32'(stall_cycles), 32'd0);
        chk("rst_flush_cnt", 32'(flush_count), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        idle("hold0", O_HOLD);
        idle("hold1", O_HOLD);
        idle("run0", O_IDLE);

        lu_cyc("lu_rs", 1'b0, O_LU);
        lu_cyc("lu_ignored", 1'b0, O_IDLE);
        idle("run1", O_IDLE);
        cyc("lu_r0", 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, O_IDLE);
        cyc("lu_rt", 1'b1, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, O_LU);
        idle("lu_rt_end", O_IDLE);
        cyc("lu_rt_unused", 1'b1, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, O_IDLE);

        lu_cyc("br_lu", 1'b1, O_FLUSH);
        lu_cyc("br_lu_still_run", 1'b0, O_LU);
        idle("lu_end", O_IDLE);

        mem_wait("mw1", 1'b0, O_MSTL);
        mem_wait("mw2", 1'b0, O_MSTL);
        mem_wait("mw3", 1'b0, O_MSTL);
        idle("mw_done", O_IDLE);
        idle("mw_run", O_IDLE);

        mem_wait("fp1", 1'b0, O_MSTL);
        mem_wait("fp2_br", 1'b1, O_MSTL);
        mem_wait("fp3_br2", 1'b1, O_MSTL);
        mem_wait("fp4", 1'b0, O_MSTL);
        idle("fp_flush", O_FLUSH);
        idle("fp_once", O_IDLE);

        lu_cyc("lu_to_mw", 1'b0, O_LU);
        mem_wait("lu_nrdy", 1'b0, O_IDLE);
        mem_wait("lu_mw", 1'b0, O_MSTL);
        idle("lu_mw_done", O_IDLE);

        lu_cyc("lu_br", 1'b0, O_LU);
        cyc("lu_br_flush", 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, O_FLUSH);
        lu_cyc("lu_br_run", 1'b0, O_LU);
        idle("lu_br_end", O_IDLE);

        for (int i = 0; i < 6; i++) mem_wait("stretch", 1'b0, O_MSTL);
        idle("stretch_done", O_IDLE);
`ifdef PIPE_HAZARD_PERF_EN
        chk("perf_stall_sat", 32'(stall_cycles), 32'(exp_stall_cnt));
        chk("perf_flush", 32'(flush_count), 32'(exp_flush_cnt));
`endif

        mem_wait("rst_fp1", 1'b0, O_MSTL);
        mem_wait("rst_fp2", 1'b1, O_MSTL);
        mem_wait("rst_fp3", 1'b0, O_MSTL);
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        #1;
        chk("midrst_out", {28'd0, stall, if_flush, idex_bubble, imem_req}, {28'd0, O_HOLD});
`ifdef PIPE_HAZARD_PERF_EN
        chk("midrst_stall_cnt", 32'(stall_cycles), 32'd0);
        chk("midrst_flush_cnt", 32'(flush_count), 32'd0);
`endif
        @(negedge clk);
        chk("midrst_noflush", {31'd0, if_flush}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle("rhold0", O_HOLD);
        idle("rhold1", O_HOLD);
        idle("rrun", O_IDLE);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
